// File: rtl/spike_packet_encoder.sv
// Snapshots cluster spike flags at each timestep boundary and emits one {node, ts, neuron} packet per set flag.
// First packet valid one cycle after the boundary edge, then one per cycle; packet_out holds steady while ready is low.
module spike_packet_encoder #(
    parameter int NUM_NEURONS     = 16,
    parameter int NEURON_ID_WIDTH = 4,
    parameter int NODE_ID_WIDTH   = 8,
    parameter int TIMESTEP_WIDTH  = 8
) (
    input  logic                                                   CLK,
    input  logic                                                   reset,
    input  logic                                                   clear,
    input  logic [NUM_NEURONS-1:0]                                 spike_in,
    input  logic [NODE_ID_WIDTH-1:0]                               node_id,
    output logic [NODE_ID_WIDTH+TIMESTEP_WIDTH+NEURON_ID_WIDTH-1:0] packet_out,
    output logic                                                   packet_valid,
    input  logic                                                   packet_ready,
    output logic                                                   busy,
    output logic [TIMESTEP_WIDTH-1:0]                              timestep,
    output logic                                                   overflow
);

    localparam int PKT_W = NODE_ID_WIDTH + TIMESTEP_WIDTH + NEURON_ID_WIDTH;

    // LOAD is the single bubble cycle in which the first packet is built from the fresh snapshot.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_clear_d;
    logic [NUM_NEURONS-1:0]      r_snap;
    logic [TIMESTEP_WIDTH-1:0]   r_ts_tag;
    logic [TIMESTEP_WIDTH-1:0]   r_timestep;
    logic                        r_overflow;
    logic [PKT_W-1:0]            r_pkt;
    logic                        r_valid;
    logic                        r_busy;
    logic [NEURON_ID_WIDTH-1:0]  r_nid;

    logic                        w_boundary;
    logic                        w_hs;
    logic [NUM_NEURONS-1:0]      w_snap_left;
    logic                        w_load;
    logic [NEURON_ID_WIDTH-1:0]  w_load_id;
    logic                        w_done;

    function automatic logic [NEURON_ID_WIDTH-1:0] f_lowest(input logic [NUM_NEURONS-1:0] v);
        f_lowest = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (v[i]) begin
                f_lowest = NEURON_ID_WIDTH'(i);
            end
        end
    endfunction

    assign w_boundary  = clear & ~r_clear_d;
    assign w_hs        = r_valid & packet_ready;
    assign w_snap_left = r_snap & ~(NUM_NEURONS'(1) << r_nid);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_id   = '0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_boundary && (|spike_in)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_load_id   = f_lowest(r_snap);
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_hs) begin
                    if (|w_snap_left) begin
                        w_load    = 1'b1;
                        w_load_id = f_lowest(w_snap_left);
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clear_d  <= 1'b0;
            r_snap     <= '0;
            r_ts_tag   <= '0;
            r_timestep <= '0;
            r_overflow <= 1'b0;
            r_pkt      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_nid      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clear_d <= clear;

            // A boundary outside IDLE (including the last-handshake cycle) drops the new snapshot.
            if (w_boundary) begin
                r_timestep <= r_timestep + 1'b1;
                if (r_state == S_IDLE) begin
                    r_snap   <= spike_in;
                    r_ts_tag <= r_timestep;
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            if (r_state == S_SEND && w_hs) begin
                r_snap <= w_snap_left;
            end

            if (w_load) begin
                r_pkt   <= {node_id, r_ts_tag, w_load_id};
                r_nid   <= w_load_id;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
            end else if (w_done) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign packet_out   = r_pkt;
    assign packet_valid = r_valid;
    assign busy         = r_busy;
    assign timestep     = r_timestep;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_spike_packet_encoder.sv
// Bench for spike_packet_encoder: scoreboard of expected packets plus table vectors and hand-written corner sequences.
module tb_spike_packet_encoder;

    localparam int NN = 16;
    localparam int NW = 4;
    localparam int DW = 8;
    localparam int TW = 8;
    localparam int PW = DW + TW + NW;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [NN-1:0] spike_in = '0;
    logic [DW-1:0] node_id = 8'h2A;
    logic          packet_ready = 1'b0;
    logic [PW-1:0] packet_out;
    logic          packet_valid;
    logic          busy;
    logic [TW-1:0] timestep;
    logic          overflow;

    spike_packet_encoder #(
        .NUM_NEURONS(NN), .NEURON_ID_WIDTH(NW), .NODE_ID_WIDTH(DW), .TIMESTEP_WIDTH(TW)
    ) dut (
        .CLK(CLK), .reset(reset), .clear(clear), .spike_in(spike_in), .node_id(node_id),
        .packet_out(packet_out), .packet_valid(packet_valid), .packet_ready(packet_ready),
        .busy(busy), .timestep(timestep), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int            checks = 0;
    int            errors = 0;
    int            hs_cnt = 0;
    logic [PW-1:0] sb[$];
    logic [TW-1:0] exp_ts = '0;

    typedef struct {
        logic [NN-1:0] spikes;
        logic [DW-1:0] node;
        int            exp_cnt;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_snap(input logic [NN-1:0] s);
        for (int i = 0; i < NN; i++) begin
            if (s[i]) sb.push_back({node_id, exp_ts, NW'(i)});
        end
    endtask

    task automatic boundary(input logic [NN-1:0] s, input bit accept);
        spike_in = s;
        clear    = 1'b1;
        if (accept) push_snap(s);
        exp_ts++;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_ts = '0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d packets pending, expected 0", name, sb.size());
            sb.delete();
        end
        tick();
        check({name, "_valid_low"}, {31'd0, packet_valid}, 32'd0);
    endtask

    // Handshake happens at the next rising edge; inputs are stable from negedge to posedge.
    always @(negedge CLK) begin
        if (!reset && packet_valid === 1'b1 && packet_ready === 1'b1) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_packet: got %h, expected none", packet_out);
            end else begin
                check("packet", {12'd0, packet_out}, {12'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        vecs[0] = '{16'h0001, 8'h11, 1};
        vecs[1] = '{16'h8000, 8'hFE, 1};
        vecs[2] = '{16'hAAAA, 8'h3C, 8};
        vecs[3] = '{16'h0F0F, 8'h00, 8};
        vecs[4] = '{16'h0000, 8'h55, 0};
        vecs[5] = '{16'h1248, 8'hA5, 4};

        tick();
        do_reset();
        check("rst_valid", {31'd0, packet_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pkt", {12'd0, packet_out}, 32'd0);
        check("rst_ts", {24'd0, timestep}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // 1: empty boundary then two spikes with ready high
        node_id = 8'h2A;
        packet_ready = 1'b1;
        boundary(16'h0000, 1);
        tick();
        check("t1_ts1", {24'd0, timestep}, 32'd1);
        check("t1_no_pkt", {31'd0, packet_valid}, 32'd0);
        check("t1_model", {12'd0, sb.size() == 0 ? 20'd0 : 20'd1}, 32'd0);
        boundary(16'h0005, 1);
        check("t1_bubble", {31'd0, packet_valid}, 32'd0);
        tick();
        check("t1_valid", {31'd0, packet_valid}, 32'd1);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        check("t1_busy_c2", {31'd0, busy}, 32'd1);
        tick();
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_valid_end", {31'd0, packet_valid}, 32'd0);
        check("t1_ts2", {24'd0, timestep}, 32'd2);
        check("t1_sb_empty", sb.size(), 32'd0);

        // 2: backpressure for 5 cycles
        packet_ready = 1'b0;
        boundary(16'h8001, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", {31'd0, packet_valid}, 32'd1);
            check("t2_stall_pkt", {12'd0, packet_out}, {12'd0, sb[0]});
            tick();
        end
        packet_ready = 1'b1;
        drain(10, "t2");

        // table vectors, ready held high
        for (int v = 0; v < 6; v++) begin
            node_id = vecs[v].node;
            hs0 = hs_cnt;
            boundary(vecs[v].spikes, 1);
            drain(40, "vec");
            check("vec_count", hs_cnt - hs0, vecs[v].exp_cnt);
            check("vec_ts", {24'd0, timestep}, {24'd0, exp_ts});
        end

        // 3: overrun while stalled
        node_id = 8'h2A;
        packet_ready = 1'b0;
        hs0 = hs_cnt;
        boundary(16'hFFFF, 1);
        repeat (3) tick();
        check("t3_ovf_before", {31'd0, overflow}, 32'd0);
        boundary(16'hFFFF, 0);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_ts", {24'd0, timestep}, {24'd0, exp_ts});
        packet_ready = 1'b1;
        drain(40, "t3");
        check("t3_count", hs_cnt - hs0, 32'd16);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // 4: clear held high for 10 cycles
        hs0 = hs_cnt;
        spike_in = 16'h0010;
        clear = 1'b1;
        push_snap(16'h0010);
        exp_ts++;
        repeat (10) tick();
        clear = 1'b0;
        drain(20, "t4");
        check("t4_count", hs_cnt - hs0, 32'd1);
        check("t4_ts", {24'd0, timestep}, {24'd0, exp_ts});

        // 5: timestep wrap
        do_reset();
        check("t5_ovf_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            boundary(16'h0000, 1);
            tick();
        end
        check("t5_wrap", {24'd0, timestep}, 32'd0);
        boundary(16'h0002, 1);
        drain(10, "t5");

        // boundary coinciding with the last handshake counts as overrun
        hs0 = hs_cnt;
        boundary(16'h0001, 1);
        tick();
        spike_in = 16'h0003;
        clear = 1'b1;
        exp_ts++;
        tick();
        clear = 1'b0;
        check("lasths_ovf", {31'd0, overflow}, 32'd1);
        check("lasths_ts", {24'd0, timestep}, {24'd0, exp_ts});
        drain(10, "lasths");
        check("lasths_count", hs_cnt - hs0, 32'd1);

        // 6: reset after three packets
        packet_ready = 1'b1;
        hs0 = hs_cnt;
        spike_in = 16'h00FF;
        clear = 1'b1;
        push_snap(16'h0007);
        exp_ts++;
        tick();
        clear = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid", {31'd0, packet_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ts", {24'd0, timestep}, 32'd0);
        check("t6_ovf", {31'd0, overflow}, 32'd0);
        check("t6_sent", hs_cnt - hs0, 32'd3);
        check("t6_sb_empty", sb.size(), 32'd0);
        sb.delete();
        exp_ts = '0;
        repeat (20) tick();
        check("t6_quiet", hs_cnt - hs0, 32'd3);
        check("t6_valid_late", {31'd0, packet_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_packet_encoder.md
Name: spike_packet_encoder

Overview:
- Transmit side of the neuron-to-network interface.
- Each potential adder raises a spike flag that is valid when the timestep ends, which is the clear boundary.
- At each clear rising edge this block snapshots the spike flags of one cluster of neurons. It serialises every set flag into a spike packet tagged with node ID, timestep and neuron ID, and delivers the packets one per handshake to the local NoC router.

Parameters:
- NUM_NEURONS, 16, number of potential adders in the cluster (spike_in width).
- NEURON_ID_WIDTH, 4, neuron index width; must equal clog2(NUM_NEURONS).
- NODE_ID_WIDTH, 8, router node address width.
- TIMESTEP_WIDTH, 8, timestep tag width; the counter wraps modulo 2^TIMESTEP_WIDTH.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  timestep boundary; the same signal that clears the potential adders.
- spike_in  input  NUM_NEURONS  spike flags from the potential adders; bit i belongs to neuron i.
- node_id  input  NODE_ID_WIDTH  static address of this node.
- packet_out  output  NODE_ID_WIDTH+TIMESTEP_WIDTH+NEURON_ID_WIDTH  packet {node_id, timestep, neuron_id}; MSB first.
- packet_valid  output  1  packet_out holds a valid packet.
- packet_ready  input  1  router accepts the packet.
- busy  output  1  a snapshot is still being sent.
- timestep  output  TIMESTEP_WIDTH  current timestep count.
- overflow  output  1  sticky flag: a snapshot was dropped.

Behaviour:
- Reset (synchronous, active-high): the next edge forces the following.
  - State goes to IDLE.
  - packet_valid=0, busy=0, packet_out=0, timestep=0, overflow=0.
  - The snapshot register and clear_d are cleared.
  - Reset during SEND abandons any remaining packets; packet_valid is low in the cycle after the reset edge.
- Edge detect: clear_d registers clear. A boundary is a cycle with clear=1 and clear_d=0. Holding clear high for several cycles produces one boundary only.
- IDLE, boundary seen:
  - snap <= spike_in, ts_tag <= timestep, timestep <= timestep+1 (wraps from 2^W-1 to 0).
  - If spike_in is non-zero, go to SEND; otherwise stay in IDLE and emit no packets.
- SEND:
  - packet_valid=1 and busy=1.
  - neuron_id is the index of the lowest set bit of snap (priority from LSB).
  - packet_out = {node_id, ts_tag, neuron_id}. It is registered and stays stable while packet_valid=1 and packet_ready=0.
  - On a handshake (packet_valid and packet_ready), that bit of snap is cleared.
  - If other bits remain, the next packet is presented in the next cycle, giving back-to-back throughput of one packet per cycle.
  - If no bits remain, the block returns to IDLE and packet_valid=0 in the next cycle.
- Latency: boundary detected at edge N gives packet_valid=1 after edge N+1. With packet_ready held high, K spikes complete in K cycles.
- Boundary during SEND (overrun):
  - The new spike_in is dropped and overflow is set to 1. overflow stays set until reset.
  - timestep still increments.
  - The current snapshot continues sending with its original ts_tag.
- Boundary in the same cycle as the last handshake: the state is still SEND in that cycle, so it counts as an overrun; the snapshot is dropped and overflow is set.
- packet_ready while packet_valid=0: ignored.
- node_id is sampled whenever a packet is loaded; it is not latched at the boundary.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Spikes with ready held high:
   - Stimulus: reset; node_id=8'h2A; spike_in=16'h0000; pulse clear. Then spike_in=16'h0005, packet_ready=1, pulse clear.
   - Required: the first boundary gives no packets and timestep=1.
   - The second boundary gives packets {2A,01,0} then {2A,01,2} on consecutive cycles, busy for 2 cycles, timestep=2.
2. Backpressure:
   - Stimulus: spike_in=16'h8001; packet_ready held low for 5 cycles, then high.
   - Required: packet_out={node,ts,0} stays stable for all 5 stall cycles. Then {node,ts,F} follows, and packet_valid drops after it.
3. Overrun:
   - Stimulus: spike_in=16'hFFFF, packet_ready=0; pulse clear twice, 4 cycles apart.
   - Required: overflow=1 after the second boundary; timestep advanced by 2.
   - Once ready goes high, exactly 16 packets are emitted, all with the first ts_tag.
4. Long clear:
   - Stimulus: clear held high for 10 cycles with spike_in=16'h0010.
   - Required: exactly one packet (neuron_id=4); timestep increments once.
5. Timestep wrap:
   - Stimulus: 256 boundaries with spike_in=0, then spike_in=16'h0002.
   - Required: timestep wraps to 0; the packet carries ts_tag=0x00 and neuron_id=1.
6. Reset mid-send:
   - Stimulus: spike_in=16'h00FF, ready=1; assert reset after 3 packets.
   - Required: packet_valid=0 in the cycle after reset; busy=0, timestep=0, overflow=0; no further packets.
